iter_muldiv: RTL and testbench
==============================

// Module: iter_muldiv
// PURPOSE
//  Parametrised iterative multiply/divide unit for the EX stage. Replaces the
//  separate mul/div blocks with one shared datapath supporting signed and
//  unsigned MULT/DIV. It adds a busy/ready/annul handshake, divide-by-zero
//  detection and a defined overflow result. EX drives start_i and holds
//  stallreq while busy_o is high; the HI/LO write logic consumes result_o.
// PARAMETERS
//  WIDTH   32  operand width; result is 2*WIDTH bits
// PORTS
//  clk           in   1        clock, rising edge
//  rst           in   1        asynchronous reset, active-low (unit reset while rst==0)
//  start_i       in   1        request an operation; sampled only in IDLE
//  op_i          in   2        00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//  opdata1_i     in   WIDTH    multiplicand / dividend
//  opdata2_i     in   WIDTH    multiplier / divisor
//  annul_i       in   1        abort current operation (pipeline flush)
//  busy_o        out  1        operation in progress (CALC or FIX)
//  ready_o       out  1        one-cycle pulse: result_o valid
//  result_o      out  2*WIDTH  MUL: {hi,lo} product; DIV: {remainder,quotient}
//  div_zero_o    out  1        set with ready_o when the divisor was 0
// BEHAVIOUR
//  Reset: all state to IDLE; busy_o=0, ready_o=0, result_o=0, div_zero_o=0.
//  FSM: IDLE -> CALC -> FIX -> DONE -> IDLE.
//   IDLE: start_i=1 and annul_i=0 latches op_i and operands -> CALC; count=0.
//     Signed ops latch absolute values plus sign bits; |MIN_INT| = 2^(WIDTH-1) unsigned.
//     DIV/DIVU with opdata2_i==0 -> DONE directly (no CALC/FIX).
//   CALC: exactly WIDTH cycles; one shift-add (MUL) or restoring subtract-shift (DIV) per cycle.
//   FIX: 1 cycle sign correction. Product negated if sign1^sign2.
//     Quotient negated if sign1^sign2; remainder takes the dividend's sign.
//   DONE: ready_o=1 for this cycle only -> IDLE.
//  Latency: start accepted at edge N -> ready_o high in cycle N+WIDTH+2.
//   Divide by zero: ready_o high in cycle N+1.
//  result_o updates at the FIX->DONE edge. It holds stable until the next accepted start.
//   No intermediate values appear on result_o.
//  busy_o = (state==CALC || state==FIX); it is 0 in DONE, so EX releases its stall with ready_o.
//  Divide-by-zero result: {opdata1_i, {WIDTH{1'b1}}}, div_zero_o=1.
//   div_zero_o clears on the next accepted start.
//  Overflow: signed MIN_INT / -1 -> quotient MIN_INT, remainder 0, no flag.
//  start_i while not IDLE: ignored (no queueing).
//  annul_i=1 in any state: next edge -> IDLE, no ready_o pulse, result_o keeps its old value.
//   annul_i has priority over start_i in the same cycle.
//  Async reset mid-operation: immediate IDLE, outputs to reset values, the operation is lost.
//  Width rules: the MUL accumulator is 2*WIDTH bits. The DIV partial remainder is
//   WIDTH+1 bits so the subtract borrow is visible. Counter width is $clog2(WIDTH+1).
// STRUCTURE
//  Shared include (lib/defines.vh) holds:
//   op encodings MD_MULT/MD_MULTU/MD_DIV/MD_DIVU;
//   state codes MD_IDLE/MD_CALC/MD_FIX/MD_DONE;
//   MdStart/MdStop, MdResultReady/MdResultNotReady.
//  One sub-module, md_sign_fix: combinational conditional negation of a 2*WIDTH
//   value, used for operand abs and result correction.
//  Everything else stays in a single always block for the FSM and datapath registers.
// TESTING (WIDTH=32)
//  MULT -3 * 5 -> ready_o at cycle 34, result_o=64'hFFFFFFFF_FFFFFFF1.
//  DIVU 100 / 7 -> result_o=64'h00000002_0000000E, div_zero_o=0.
//  DIV -7 / 2 -> result_o=64'hFFFFFFFF_FFFFFFFD.
//  DIV 0x80000000 / 0xFFFFFFFF -> result_o=64'h00000000_80000000, no flag.
//  DIVU 5 / 0 -> ready_o next cycle, result_o=64'h00000005_FFFFFFFF, div_zero_o=1.
//  MULTU started, annul_i pulsed at cycle 10 -> IDLE, no ready_o, old result_o kept.
//   A following start completes normally.
//  Also check: start_i while busy is ignored; rst low mid-CALC clears everything;
//   result_o holds after ready_o.

Source files
------------

// File: rtl/iter_muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package iter_muldiv_pkg;

    // Operation select on op_i
    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    // Sequencer states
    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_CALC = 2'b01,
        MD_FIX  = 2'b10,
        MD_DONE = 2'b11
    } md_state_e;

    localparam logic MdStart          = 1'b1;
    localparam logic MdStop           = 1'b0;
    localparam logic MdResultReady    = 1'b1;
    localparam logic MdResultNotReady = 1'b0;

endpackage

// File: rtl/iter_muldiv_md_sign_fix.sv
// Conditional two's-complement negation; used for operand magnitude and
// for the final sign correction of product, quotient and remainder.
module md_sign_fix #(
    parameter int N = 64
) (
    input  logic [N-1:0] value_in,
    input  logic         neg,
    output logic [N-1:0] value_out
);

    assign value_out = neg ? (~value_in + {{(N-1){1'b0}}, 1'b1}) : value_in;

endmodule

// File: rtl/iter_muldiv.sv
// Iterative signed/unsigned multiply and divide for the EX stage.
// MUL: WIDTH shift-add steps on magnitudes; DIV: WIDTH restoring steps.
// A single FIX cycle applies the sign, then ready_o pulses for one cycle.
module iter_muldiv
    import iter_muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [1:0]         op_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               annul_i,
    output logic               busy_o,
    output logic               ready_o,
    output logic [2*WIDTH-1:0] result_o,
    output logic               div_zero_o
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    md_state_e          state;
    logic               is_div;
    logic               sign1, sign2;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] mcand, prod;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   rem, quot, divisor;

    logic               signed_op, sign_a, sign_b;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     partial, diff;
    logic [2*WIDTH-1:0] prod_fixed, fix_result;
    logic [WIDTH-1:0]   quot_fixed, rem_fixed;

    // Operand magnitudes: MIN_INT maps to 2^(WIDTH-1) as an unsigned value
    assign signed_op = (op_i == MD_MULT) || (op_i == MD_DIV);
    assign sign_a    = signed_op & opdata1_i[WIDTH-1];
    assign sign_b    = signed_op & opdata2_i[WIDTH-1];

    md_sign_fix #(.N(WIDTH)) u_abs_a (.value_in(opdata1_i), .neg(sign_a), .value_out(abs_a));
    md_sign_fix #(.N(WIDTH)) u_abs_b (.value_in(opdata2_i), .neg(sign_b), .value_out(abs_b));

    // Restoring divide step; diff[WIDTH] is the borrow (partial < divisor)
    assign partial = {rem, quot[WIDTH-1]};
    assign diff    = partial - {1'b0, divisor};

    // Sign correction: quotient/product by sign1^sign2, remainder by dividend sign.
    // MIN_INT / -1 wraps back to MIN_INT with remainder 0 on its own.
    md_sign_fix #(.N(2*WIDTH)) u_fix_prod (.value_in(prod), .neg(sign1 ^ sign2), .value_out(prod_fixed));
    md_sign_fix #(.N(WIDTH))   u_fix_quot (.value_in(quot), .neg(sign1 ^ sign2), .value_out(quot_fixed));
    md_sign_fix #(.N(WIDTH))   u_fix_rem  (.value_in(rem),  .neg(sign1),         .value_out(rem_fixed));

    assign fix_result = is_div ? {rem_fixed, quot_fixed} : prod_fixed;

    // Sequencer and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= MD_IDLE;
            is_div     <= 1'b0;
            sign1      <= 1'b0;
            sign2      <= 1'b0;
            count      <= '0;
            mcand      <= '0;
            prod       <= '0;
            mplier     <= '0;
            rem        <= '0;
            quot       <= '0;
            divisor    <= '0;
            busy_o     <= MdStop;
            ready_o    <= MdResultNotReady;
            result_o   <= '0;
            div_zero_o <= 1'b0;
        end else if (annul_i) begin
            // Flush: drop the operation, keep the last published result
            state   <= MD_IDLE;
            busy_o  <= MdStop;
            ready_o <= MdResultNotReady;
        end else begin
            case (state)
                MD_IDLE: begin
                    ready_o <= MdResultNotReady;
                    if (start_i == MdStart) begin
                        is_div     <= op_i[1];
                        sign1      <= sign_a;
                        sign2      <= sign_b;
                        count      <= '0;
                        div_zero_o <= 1'b0;
                        if (op_i[1] && (opdata2_i == '0)) begin
                            state      <= MD_DONE;
                            result_o   <= {opdata1_i, {WIDTH{1'b1}}};
                            div_zero_o <= 1'b1;
                            ready_o    <= MdResultReady;
                        end else begin
                            state   <= MD_CALC;
                            busy_o  <= MdStart;
                            mcand   <= {{WIDTH{1'b0}}, abs_a};
                            mplier  <= abs_b;
                            prod    <= '0;
                            rem     <= '0;
                            quot    <= abs_a;
                            divisor <= abs_b;
                        end
                    end
                end
                MD_CALC: begin
                    if (is_div) begin
                        rem  <= diff[WIDTH] ? partial[WIDTH-1:0] : diff[WIDTH-1:0];
                        quot <= {quot[WIDTH-2:0], ~diff[WIDTH]};
                    end else begin
                        if (mplier[0]) prod <= prod + mcand;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                    end
                    count <= count + CW'(1);
                    if (count == LAST) state <= MD_FIX;
                end
                MD_FIX: begin
                    result_o <= fix_result;
                    busy_o   <= MdStop;
                    ready_o  <= MdResultReady;
                    state    <= MD_DONE;
                end
                default: begin
                    ready_o <= MdResultNotReady;
                    state   <= MD_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iter_muldiv.sv
// Bench for iter_muldiv: table vectors, random ops against a reference
// model, and hand-written annul / reset / busy-start sequences.
module tb_iter_muldiv;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           start_i = 1'b0;
    logic [1:0]     op_i = 2'b00;
    logic [W-1:0]   opdata1_i = '0;
    logic [W-1:0]   opdata2_i = '0;
    logic           annul_i = 1'b0;
    logic           busy_o, ready_o, div_zero_o;
    logic [2*W-1:0] result_o;

    iter_muldiv #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
        .opdata1_i(opdata1_i), .opdata2_i(opdata2_i), .annul_i(annul_i),
        .busy_o(busy_o), .ready_o(ready_o), .result_o(result_o),
        .div_zero_o(div_zero_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] res;
        logic        dz;
    } vec_t;

    typedef struct {
        logic [63:0] res;
        logic        dz;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    logic [63:0] last_res = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Independent reference: SV arithmetic on 64-bit values
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b, output logic dz);
        longint sa, sb, q, r;
        logic [63:0] ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        dz = 1'b0;
        if (op == 2'd0) return 64'(sa * sb);
        if (op == 2'd1) return ua * ub;
        if (b == 32'd0) begin
            dz = 1'b1;
            return {a, 32'hFFFFFFFF};
        end
        if (op == 2'd2) begin
            q = sa / sb;
            r = sa % sb;
        end else begin
            q = longint'(ua / ub);
            r = longint'(ua % ub);
        end
        return {r[31:0], q[31:0]};
    endfunction

    // Drive a one-cycle start; optionally record the expected result
    task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] res, input logic dz, input bit push);
        exp_t e;
        @(negedge clk);
        op_i = op; opdata1_i = a; opdata2_i = b; start_i = 1'b1;
        if (push) begin
            e.res = res; e.dz = dz;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1 start_i = 1'b0;
    endtask

    // Wait for ready_o (bounded), then check latency, busy, result, pulse width, hold
    task automatic wait_ready(input int exp_lat, input string name);
        int   lat;
        bit   got;
        exp_t e;
        lat = 0;
        got = 0;
        while (lat < 100 && !got) begin
            @(negedge clk);
            lat++;
            if (lat == 1 && exp_lat > 1) check({name, " busy"}, 64'(busy_o), 64'd1);
            if (ready_o) got = 1;
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s timeout: got no ready_o expected ready_o within 100 cycles", name);
            if (sb_q.size() > 0) void'(sb_q.pop_front());
            return;
        end
        check({name, " latency"}, 64'(lat), 64'(exp_lat));
        check({name, " busy at ready"}, 64'(busy_o), 64'd0);
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: got unexpected ready_o expected none", name);
            return;
        end
        e = sb_q.pop_front();
        check({name, " result"}, result_o, e.res);
        check({name, " div_zero"}, 64'(div_zero_o), 64'(e.dz));
        last_res = e.res;
        @(negedge clk);
        check({name, " ready pulse"}, 64'(ready_o), 64'd0);
        check({name, " result hold"}, result_o, e.res);
    endtask

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{2'd0, 32'hFFFFFFFD, 32'd5,        64'hFFFFFFFF_FFFFFFF1, 1'b0};
        vecs[1]  = '{2'd3, 32'd100,      32'd7,        64'h00000002_0000000E, 1'b0};
        vecs[2]  = '{2'd2, 32'hFFFFFFF9, 32'd2,        64'hFFFFFFFF_FFFFFFFD, 1'b0};
        vecs[3]  = '{2'd2, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b0};
        vecs[4]  = '{2'd3, 32'd5,        32'd0,        64'h00000005_FFFFFFFF, 1'b1};
        vecs[5]  = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 1'b0};
        vecs[6]  = '{2'd0, 32'h80000000, 32'h80000000, 64'h40000000_00000000, 1'b0};
        vecs[7]  = '{2'd2, 32'd7,        32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 1'b0};
        vecs[8]  = '{2'd3, 32'hFFFFFFFF, 32'd1,        64'h00000000_FFFFFFFF, 1'b0};
        vecs[9]  = '{2'd2, 32'hFFFFFFFF, 32'd0,        64'hFFFFFFFF_FFFFFFFF, 1'b1};
        vecs[10] = '{2'd0, 32'h12345678, 32'd0,        64'h00000000_00000000, 1'b0};
        vecs[11] = '{2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001, 1'b0};

        // Reset state
        repeat (2) @(negedge clk);
        check("reset busy", 64'(busy_o), 64'd0);
        check("reset ready", 64'(ready_o), 64'd0);
        check("reset result", result_o, 64'd0);
        check("reset div_zero", 64'(div_zero_o), 64'd0);
        rst = 1'b1;

        // Table vectors
        for (int i = 0; i < 12; i++) begin
            launch(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].dz, 1'b1);
            wait_ready(vecs[i].dz ? 1 : W + 2, $sformatf("vec%0d", i));
        end

        // Random ops against the model
        for (int i = 0; i < 8; i++) begin
            logic [1:0]  op;
            logic [31:0] a, b;
            logic [63:0] r;
            logic        dz;
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = (i == 3) ? 32'd0 : ((i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom);
            r  = model(op, a, b, dz);
            launch(op, a, b, r, dz, 1'b1);
            wait_ready(dz ? 1 : W + 2, $sformatf("rand%0d", i));
        end

        // start_i while busy is ignored
        begin
            bit extra;
            extra = 0;
            launch(2'd3, 32'd100, 32'd7, 64'h00000002_0000000E, 1'b0, 1'b1);
            repeat (4) @(negedge clk);
            op_i = 2'd0; opdata1_i = 32'd3; opdata2_i = 32'd3; start_i = 1'b1;
            @(negedge clk);
            start_i = 1'b0;
            wait_ready(W + 2 - 5, "busy start");
            repeat (40) begin
                @(negedge clk);
                if (ready_o) extra = 1;
            end
            check("busy start no second ready", 64'(extra), 64'd0);
        end

        // annul mid-CALC: no ready, old result kept, next op completes
        begin
            bit seen;
            seen = 0;
            launch(2'd1, 32'h10, 32'h10, 64'd0, 1'b0, 1'b0);
            repeat (9) @(negedge clk);
            annul_i = 1'b1;
            @(negedge clk);
            annul_i = 1'b0;
            check("annul busy", 64'(busy_o), 64'd0);
            repeat (40) begin
                @(negedge clk);
                if (ready_o) seen = 1;
            end
            check("annul no ready", 64'(seen), 64'd0);
            check("annul result kept", result_o, last_res);
            launch(2'd0, 32'hFFFFFFFD, 32'd5, 64'hFFFFFFFF_FFFFFFF1, 1'b0, 1'b1);
            wait_ready(W + 2, "after annul");
        end

        // Async reset mid-CALC clears everything immediately
        launch(2'd1, 32'h1234, 32'h5678, 64'd0, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("midreset busy", 64'(busy_o), 64'd0);
        check("midreset ready", 64'(ready_o), 64'd0);
        check("midreset result", result_o, 64'd0);
        check("midreset div_zero", 64'(div_zero_o), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        launch(2'd2, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 1'b0, 1'b1);
        wait_ready(W + 2, "after reset");

        check("scoreboard empty", 64'(sb_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
